// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// The round-robin search here is also used by the read-side scheduler.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam int STAT_W    = 16;
    localparam int MAX_REQ   = 32;
    localparam int MAX_REQ_W = 5;

    // First set bit of req at or above ptr, wrapping modulo n; returns ptr when req is empty.
    function automatic int unsigned next_rr(input int unsigned           ptr,
                                            input logic [MAX_REQ-1:0]    req,
                                            input int unsigned           n);
        int unsigned win;
        int unsigned off;
        int unsigned c;
        win = ptr;
        for (int unsigned k = MAX_REQ; k > 0; k--) begin
            off = k - 1;
            c   = (ptr + off) % n;
            if (off < n && req[c[MAX_REQ_W-1:0]]) begin
                win = c;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational rotating-priority picker: one-hot winner and its index,
// searching upward from rr_ptr_i. One-hot is all zero when no request is set.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [PTR_W-1:0]   idx_o
);

    logic [MAX_REQ-1:0] req_ext;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        req_ext                = '0;
        onehot_o               = '0;
        req_ext[NUM_REQ-1:0]   = req_i;
        idx_o                  = PTR_W'(next_rr(32'(rr_ptr_i), req_ext, NUM_REQ));
        if (|req_i) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_STATS_EN to add per-requester word counters and a stall counter.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                     wclk,
    input  logic                     wrst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     full,
    output logic                     write_en,
    output logic [WIDTH-1:0]         wdata,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] word_cnt,
    output logic [STAT_W-1:0]         stall_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_e                          state_q, state_d;
    logic [NUM_REQ-1:0]              grant_q, grant_d;
    logic [PTR_W-1:0]                owner_q, owner_d;
    logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]                beat_cnt_q, beat_cnt_d;

    logic [NUM_REQ-1:0][WIDTH-1:0]   req_data_arr;
    logic [NUM_REQ-1:0]              pick_onehot;
    logic [PTR_W-1:0]                pick_idx;
    logic                            in_burst;
    logic                            owner_valid;
    logic                            accept;
    logic                            burst_done;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_i    (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    assign req_data_arr = req_data;
    assign in_burst     = (state_q == BURST);
    assign owner_valid  = req_valid[owner_q];
    assign accept       = in_burst && owner_valid && !full && !wrst;
    assign burst_done   = accept && (req_last[owner_q] || beat_cnt_q == CNT_W'(MAX_BURST - 1));

    // Ready and write strobe are gated by reset combinationally so nothing is accepted during wrst.
    assign req_ready = (in_burst && !full && !wrst) ? grant_q : '0;
    assign write_en  = accept;
    assign wdata     = req_data_arr[owner_q];
    assign grant     = grant_q;
    assign busy      = in_burst;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d    = BURST;
                    grant_d    = pick_onehot;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (burst_done) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (wrst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] word_cnt_q;
    logic [STAT_W-1:0]              stall_cnt_q;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept && word_cnt_q[owner_q] != '1) begin
                word_cnt_q[owner_q] <= word_cnt_q[owner_q] + STAT_W'(1);
            end
            if (in_burst && owner_valid && full && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + STAT_W'(1);
            end
        end
    end

    assign word_cnt  = word_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
